seq_alu: RTL and testbench

//  Parametrised multi-cycle ALU; successor to the single-cycle datapath ALU.

---
 rtl/seq_alu.sv | 209 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake: two-cycle fast ops, iterative
// shift-add multiply and restoring divide, registered compare flags.
module seq_alu #(
    parameter int unsigned W        = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] aux,
    output logic         eq,
    output logic         gt,
    output logic         dz
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned W2 = 2 * W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_NOT = 4'd10;
    localparam logic [3:0] OP_AND = 4'd11;
    localparam logic [3:0] OP_MOV = 4'd12;

    logic [1:0]    state, nextState;
    logic [W-1:0]  aReg, bReg, nextA, nextB;
    logic [3:0]    opReg, nextOp;
    logic [W-1:0]  hi, lo, nextHi, nextLo;
    logic [CW-1:0] cnt, nextCnt;
    logic [W-1:0]  nextResult, nextAux;
    logic          nextBusy, nextDone, nextEq, nextGt, nextDz;

    logic [W2-1:0] prod;
    logic [CW-1:0] shAmt;
    logic          bigShift, iterOp, qBit;
    logic [W-1:0]  fastRes, fastAux, stepHi, stepLo;
    logic          fastDz;
    logic [W:0]    addSum, partial, trial;

    // State and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            aReg   <= '0;
            bReg   <= '0;
            opReg  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            aux    <= '0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            dz     <= 1'b0;
        end else begin
            state  <= nextState;
            aReg   <= nextA;
            bReg   <= nextB;
            opReg  <= nextOp;
            hi     <= nextHi;
            lo     <= nextLo;
            cnt    <= nextCnt;
            busy   <= nextBusy;
            done   <= nextDone;
            result <= nextResult;
            aux    <= nextAux;
            eq     <= nextEq;
            gt     <= nextGt;
            dz     <= nextDz;
        end
    end

    // Next-state, datapath step and result selection
    always_comb begin
        nextState  = state;
        nextA      = aReg;
        nextB      = bReg;
        nextOp     = opReg;
        nextHi     = hi;
        nextLo     = lo;
        nextCnt    = cnt;
        nextResult = result;
        nextAux    = aux;
        nextEq     = eq;
        nextGt     = gt;
        nextDz     = dz;
        nextBusy   = 1'b0;
        nextDone   = 1'b0;
        fastRes    = '0;
        fastAux    = '0;
        fastDz     = 1'b0;

        prod     = W2'(aReg) * W2'(bReg);
        shAmt    = bReg[CW-1:0];
        bigShift = (bReg >= W'(W));
        iterOp   = ((opReg == OP_MUL) && !FAST_MUL) ||
                   (((opReg == OP_DIV) || (opReg == OP_MOD)) && (bReg != '0));

        // One shift-add or one restoring-subtract step on {hi, lo}
        addSum  = {1'b0, hi} + (lo[0] ? {1'b0, bReg} : '0);
        partial = {hi, lo[W-1]};
        trial   = partial - {1'b0, bReg};
        qBit    = ~trial[W];
        if (opReg == OP_MUL) begin
            stepHi = addSum[W:1];
            stepLo = {addSum[0], lo[W-1:1]};
        end else begin
            stepHi = qBit ? trial[W-1:0] : partial[W-1:0];
            stepLo = {lo[W-2:0], qBit};
        end

        case (opReg)
            OP_ADD: fastRes = aReg + bReg;
            OP_SUB: fastRes = aReg - bReg;
            OP_MUL: {fastAux, fastRes} = prod;
            OP_DIV: begin
                fastRes = '1;
                fastAux = aReg;
                fastDz  = 1'b1;
            end
            OP_MOD: begin
                fastRes = aReg;
                fastAux = '1;
                fastDz  = 1'b1;
            end
            OP_LSL: fastRes = bigShift ? '0 : (aReg << shAmt);
            OP_LSR: fastRes = bigShift ? '0 : (aReg >> shAmt);
            OP_ASR: fastRes = bigShift ? {W{aReg[W-1]}} : W'($signed(aReg) >>> shAmt);
            OP_OR:  fastRes = aReg | bReg;
            OP_NOT: fastRes = ~bReg;
            OP_AND: fastRes = aReg & bReg;
            OP_MOV: fastRes = bReg;
            default: fastRes = '0;
        endcase

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nextState = LOAD;
                    nextA     = a_in;
                    nextB     = b_in;
                    nextOp    = op;
                end else begin
                    nextState = IDLE;
                end
            end
            LOAD: begin
                nextHi  = '0;
                nextLo  = aReg;
                nextCnt = '0;
                if (iterOp) begin
                    nextState = RUN;
                end else begin
                    nextState  = DONE;
                    nextResult = fastRes;
                    nextAux    = fastAux;
                    nextDz     = fastDz;
                    if (opReg == OP_CMP) begin
                        nextEq = (aReg == bReg);
                        nextGt = (aReg > bReg);
                    end
                end
            end
            RUN: begin
                nextHi  = stepHi;
                nextLo  = stepLo;
                nextCnt = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    nextState = DONE;
                    nextDz    = 1'b0;
                    // Remainder goes to result and quotient to aux for the modulo op
                    if (opReg == OP_MOD) begin
                        nextResult = stepHi;
                        nextAux    = stepLo;
                    end else begin
                        nextResult = stepLo;
                        nextAux    = stepHi;
                    end
                end
            end
            default: nextState = IDLE;
        endcase

        nextBusy = (nextState == LOAD) || (nextState == RUN);
        nextDone = (nextState == DONE);
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed ops push expectations, a monitor
// pops and compares on every done pulse.
module tb_seq_alu;

    localparam int unsigned W = 32;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  CMP = 4'd2,  MUL = 4'd3;
    localparam logic [3:0] DIV = 4'd4,  MOD = 4'd5,  LSL = 4'd6,  LSR = 4'd7;
    localparam logic [3:0] ASR = 4'd8,  ORR = 4'd9,  NOTB = 4'd10, ANDB = 4'd11;
    localparam logic [3:0] MOV = 4'd12, ILL = 4'd13;

    logic         clk = 1'b0;
    logic         clr, start;
    logic [3:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, eq, gt, dz;
    logic [W-1:0] result, aux;
    logic         fBusy, fDone, fEq, fGt, fDz;
    logic [W-1:0] fResult, fAux;

    seq_alu #(.W(W), .FAST_MUL(1'b0)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .aux(aux),
        .eq(eq), .gt(gt), .dz(dz)
    );

    seq_alu #(.W(W), .FAST_MUL(1'b1)) dutFast (
        .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(fBusy), .done(fDone), .result(fResult), .aux(fAux),
        .eq(fEq), .gt(fGt), .dz(fDz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] aux;
        logic         eq;
        logic         gt;
        logic         dz;
        int           at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon;
    logic expEq = 1'b0;
    logic expGt = 1'b0;
    bit   fastArmed = 1'b0;
    int   fastAt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Monitor for the main DUT
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %0h at cycle %0d, none expected", result, cyc);
            end else begin
                mon = sbq.pop_front();
                check({mon.name, ".result"},  64'(result), 64'(mon.res));
                check({mon.name, ".aux"},     64'(aux),    64'(mon.aux));
                check({mon.name, ".eq"},      64'(eq),     64'(mon.eq));
                check({mon.name, ".gt"},      64'(gt),     64'(mon.gt));
                check({mon.name, ".dz"},      64'(dz),     64'(mon.dz));
                check({mon.name, ".latency"}, 64'(cyc),    64'(mon.at));
            end
        end
    end

    // Monitor for the fast-multiply instance during the armed MUL
    always @(negedge clk) begin
        if (fastArmed && fDone === 1'b1) begin
            fastArmed = 1'b0;
            check("fast_mul.result",  64'(fResult), 64'h0000_0000_FFFF_FFFE);
            check("fast_mul.aux",     64'(fAux),    64'h1);
            check("fast_mul.latency", 64'(cyc),     64'(fastAt));
            check("fast_mul.dz",      64'(fDz),     64'h0);
            check("fast_mul.busy",    64'(fBusy),   64'h0);
            check("fast_mul.flags",   64'({fEq, fGt}), 64'({expEq, expGt}));
        end
    end

    task automatic waitDone(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s.timeout: no done within 100 cycles, expected one", name);
    endtask

    // Called at a negedge; issues one op and returns on the negedge of its done cycle
    task automatic runOp(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res,
                         input logic [W-1:0] ax, input logic d, input int lat,
                         input bit chkFast);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.aux  = ax;
        e.eq   = expEq;
        e.gt   = expGt;
        e.dz   = d;
        e.at   = cyc + lat;
        sbq.push_back(e);
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (chkFast) begin
            fastArmed = 1'b1;
            fastAt    = e.at - lat + 2;
        end
        waitDone(name);
    endtask

    task automatic runCmp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wantEq, input logic wantGt);
        expEq = wantEq;
        expGt = wantGt;
        runOp(name, CMP, a, b, 32'h0, 32'h0, 1'b0, 2, 1'b0);
    endtask

    initial begin : main
        int c0;
        clr   = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy",   64'(busy),   64'h0);
        check("rst.done",   64'(done),   64'h0);
        check("rst.result", 64'(result), 64'h0);
        check("rst.aux",    64'(aux),    64'h0);
        check("rst.flags",  64'({eq, gt, dz}), 64'h0);
        clr = 1'b0;

        runOp("add_wrap",  ADD, 32'hFFFF_FFFF, 32'h1,  32'h0,          32'h0,         1'b0, 2,  1'b0);
        runOp("div_100_7", DIV, 32'd100,       32'd7,  32'd14,         32'd2,         1'b0, 34, 1'b0);
        runOp("mul_ff_2",  MUL, 32'hFFFF_FFFF, 32'h2,  32'hFFFF_FFFE,  32'h1,         1'b0, 34, 1'b1);
        runOp("mul_max",   MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,   32'hFFFF_FFFE, 1'b0, 34, 1'b0);
        runOp("mul_2_32",  MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,   32'h1,         1'b0, 34, 1'b0);
        runOp("mod_9_0",   MOD, 32'd9,         32'd0,  32'd9,          32'hFFFF_FFFF, 1'b1, 2,  1'b0);
        runOp("add_1_1",   ADD, 32'd1,         32'd1,  32'd2,          32'h0,         1'b0, 2,  1'b0);
        runOp("div_7_0",   DIV, 32'd7,         32'd0,  32'hFFFF_FFFF,  32'd7,         1'b1, 2,  1'b0);
        runOp("illegal",   ILL, 32'd5,         32'd6,  32'h0,          32'h0,         1'b0, 2,  1'b0);
        runOp("mod_100_7", MOD, 32'd100,       32'd7,  32'd2,          32'd14,        1'b0, 34, 1'b0);
        runOp("div_big",   DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF,  32'hF,         1'b0, 34, 1'b0);
        runOp("sub_neg",   SUB, 32'd3,         32'd5,  32'hFFFF_FFFE,  32'h0,         1'b0, 2,  1'b0);
        runCmp("cmp_5_3",  32'd5, 32'd3, 1'b0, 1'b1);
        runCmp("cmp_3_5",  32'd3, 32'd5, 1'b0, 1'b0);
        runCmp("cmp_3_3",  32'd3, 32'd3, 1'b1, 1'b0);
        runOp("asr_40",    ASR, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF,  32'h0,         1'b0, 2,  1'b0);
        runOp("asr_4",     ASR, 32'h8000_0000, 32'd4,  32'hF800_0000,  32'h0,         1'b0, 2,  1'b0);
        runOp("lsl_31",    LSL, 32'h1,         32'd31, 32'h8000_0000,  32'h0,         1'b0, 2,  1'b0);
        runOp("lsl_32",    LSL, 32'hFFFF_FFFF, 32'd32, 32'h0,          32'h0,         1'b0, 2,  1'b0);
        runOp("lsr_4",     LSR, 32'h8000_0000, 32'd4,  32'h0800_0000,  32'h0,         1'b0, 2,  1'b0);
        runOp("lsr_33",    LSR, 32'hFFFF_FFFF, 32'd33, 32'h0,          32'h0,         1'b0, 2,  1'b0);
        runOp("or",        ORR, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 32'h0,   1'b0, 2,  1'b0);
        runOp("and",       ANDB, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 32'h0,  1'b0, 2,  1'b0);
        runOp("not",       NOTB, 32'h1234_5678, 32'h0,  32'hFFFF_FFFF, 32'h0,         1'b0, 2,  1'b0);
        runOp("mov",       MOV, 32'hDEAD_BEEF, 32'h1234, 32'h1234,     32'h0,         1'b0, 2,  1'b0);
        runCmp("cmp_sign", 32'h8000_0000, 32'h1, 1'b0, 1'b1);
        runCmp("cmp_eq2",  32'hABCD_0000, 32'hABCD_0000, 1'b1, 1'b0);

        // Start while busy is dropped; clr mid-op aborts with no done
        c0    = cyc;
        op    = DIV;
        a_in  = 32'd100;
        b_in  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < c0 + 5) @(negedge clk);
        op    = ADD;
        a_in  = 32'd1;
        b_in  = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort.busy_mid", 64'(busy), 64'h1);
        while (cyc < c0 + 10) @(negedge clk);
        check("abort.busy_pre_clr", 64'(busy), 64'h1);
        clr = 1'b1;
        @(negedge clk);
        expEq = 1'b0;
        expGt = 1'b0;
        check("clr.busy",   64'(busy),   64'h0);
        check("clr.done",   64'(done),   64'h0);
        check("clr.result", 64'(result), 64'h0);
        check("clr.aux",    64'(aux),    64'h0);
        check("clr.flags",  64'({eq, gt, dz}), 64'h0);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        runOp("add_after_clr", ADD, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 2, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'h0);
        check("fast_mul_seen",    64'(fastArmed),  64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
